// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer: fetch/decode/execute FSM that emits a one-cycle
// control word per state for a simple accumulator datapath.
module control_sequencer #(
  parameter int unsigned SZ = 27
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          run,
  input  logic [7:0]    ir,
  output logic [SZ-1:0] CS_bus,
  output logic [3:0]    state,
  output logic          halted
);

  localparam int unsigned BitAdd    = 0;
  localparam int unsigned BitComp   = 1;
  localparam int unsigned BitSub    = 2;
  localparam int unsigned BitXorr   = 3;
  localparam int unsigned BitAndd   = 4;
  localparam int unsigned BitOrr    = 5;
  localparam int unsigned BitAccIn  = 6;
  localparam int unsigned BitAccOut = 7;
  localparam int unsigned BitPcOut  = 8;
  localparam int unsigned BitPcInc  = 9;
  localparam int unsigned BitPcIn   = 10;
  localparam int unsigned BitMarIn  = 11;
  localparam int unsigned BitMemRd  = 12;
  localparam int unsigned BitMdrOut = 14;
  localparam int unsigned BitIrIn   = 15;
  localparam int unsigned BitBIn    = 16;
  localparam int unsigned BitBOut   = 17;
  localparam int unsigned BitCIn    = 18;
  localparam int unsigned BitCOut   = 19;
  localparam int unsigned BitFlagIn = 20;
  localparam int unsigned BitZOut   = 25;
  localparam int unsigned BitDone   = 26;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StF0   = 4'd1,
    StF1   = 4'd2,
    StF2   = 4'd3,
    StDec  = 4'd4,
    StI0   = 4'd5,
    StI1   = 4'd6,
    StE1   = 4'd7,
    StE2   = 4'd8,
    StHalt = 4'd9
  } state_e;

  state_e state_q, state_d;
  logic   run_q;
  logic [26:0] cw;

  logic [3:0] op;
  logic [1:0] src;
  logic       is_alu, is_cmp, is_mov, is_ldi, is_jmp, is_hlt, is_nop, need_imm;

  assign op       = ir[7:4];
  assign src      = ir[1:0];
  assign is_alu   = (op >= 4'd1) && (op <= 4'd5);
  assign is_cmp   = (op == 4'd6);
  assign is_mov   = (op == 4'd7);
  assign is_ldi   = (op == 4'd8);
  assign is_jmp   = (op == 4'd9);
  assign is_hlt   = (op == 4'd10);
  assign is_nop   = (op == 4'd0) || (op >= 4'd11);
  // Immediate operands need an extra memory fetch through I0/I1.
  assign need_imm = ((is_alu || is_cmp) && (src == 2'd2)) || is_ldi || is_jmp;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
    end
  end

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = run ? StF0 : StIdle;
      StF0:    state_d = StF1;
      StF1:    state_d = StF2;
      StF2:    state_d = StDec;
      StDec: begin
        if (is_hlt)        state_d = StHalt;
        else if (is_nop)   state_d = StF0;
        else if (need_imm) state_d = StI0;
        else               state_d = StE1;
      end
      StI0:    state_d = StI1;
      StI1:    state_d = StE1;
      StE1:    state_d = is_alu ? StE2 : StF0;
      StE2:    state_d = StF0;
      StHalt:  state_d = (run && !run_q) ? StF0 : StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cw = '0;
    unique case (state_q)
      StF0, StI0: begin
        cw[BitPcOut] = 1'b1;
        cw[BitMarIn] = 1'b1;
      end
      StF1, StI1: begin
        cw[BitMemRd] = 1'b1;
        cw[BitPcInc] = 1'b1;
      end
      StF2: begin
        cw[BitMdrOut] = 1'b1;
        cw[BitIrIn]   = 1'b1;
      end
      StDec:   cw[BitDone] = is_nop || is_hlt;
      StE1: begin
        if (is_alu || is_cmp) begin
          unique case (src)
            2'd0: cw[BitBOut]   = 1'b1;
            2'd1: cw[BitCOut]   = 1'b1;
            2'd2: cw[BitMdrOut] = 1'b1;
            2'd3: cw[BitAccOut] = 1'b1;
            default: ;
          endcase
        end
        if (is_alu) begin
          unique case (op)
            4'd1: cw[BitAdd]  = 1'b1;
            4'd2: cw[BitSub]  = 1'b1;
            4'd3: cw[BitXorr] = 1'b1;
            4'd4: cw[BitAndd] = 1'b1;
            4'd5: cw[BitOrr]  = 1'b1;
            default: ;
          endcase
        end else if (is_cmp) begin
          cw[BitComp]   = 1'b1;
          cw[BitFlagIn] = 1'b1;
          cw[BitDone]   = 1'b1;
        end else if (is_mov) begin
          cw[BitAccOut] = 1'b1;
          cw[BitBIn]    = ~ir[0];
          cw[BitCIn]    = ir[0];
          cw[BitDone]   = 1'b1;
        end else if (is_ldi || is_jmp) begin
          cw[BitMdrOut] = 1'b1;
          cw[BitAccIn]  = is_ldi;
          cw[BitPcIn]   = is_jmp;
          cw[BitDone]   = 1'b1;
        end
      end
      // ALU result is registered, so it is written back one cycle after E1.
      StE2: begin
        cw[BitZOut]  = 1'b1;
        cw[BitAccIn] = 1'b1;
        cw[BitDone]  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    CS_bus        = '0;
    CS_bus[26:0]  = cw;
  end

  assign state  = state_q;
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a per-instruction
// expected-trace model built from the instruction-set rules.
module tb_control_sequencer;

  localparam int unsigned SZ = 27;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          run = 1'b0;
  logic [7:0]    ir = 8'h00;
  logic [SZ-1:0] CS_bus;
  logic [3:0]    state;
  logic          halted;

  int total = 0;
  int bad   = 0;

  control_sequencer #(.SZ(SZ)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .run    (run),
    .ir     (ir),
    .CS_bus (CS_bus),
    .state  (state),
    .halted (halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  st;
    logic [26:0] cw;
  } step_t;

  step_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] bits(input int a, input int b = -1, input int c = -1,
                                       input int d = -1);
    logic [26:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Expected (state, control word) trace of one instruction, starting at F0.
  task automatic build(input logic [7:0] instr);
    int op;
    int src;
    int src_bit[4];
    int alu_bit[6];
    op      = int'(instr[7:4]);
    src     = int'(instr[1:0]);
    src_bit = '{17, 19, 14, 7};
    alu_bit = '{0, 0, 2, 3, 4, 5};
    exp_q.delete();
    exp_q.push_back(step_t'{4'd1, bits(8, 11)});
    exp_q.push_back(step_t'{4'd2, bits(12, 9)});
    exp_q.push_back(step_t'{4'd3, bits(14, 15)});
    if (op == 0 || op >= 10) begin
      exp_q.push_back(step_t'{4'd4, bits(26)});
      return;
    end
    exp_q.push_back(step_t'{4'd4, 27'd0});
    if ((op <= 6 && src == 2) || op == 8 || op == 9) begin
      exp_q.push_back(step_t'{4'd5, bits(8, 11)});
      exp_q.push_back(step_t'{4'd6, bits(12, 9)});
    end
    if (op <= 5) begin
      exp_q.push_back(step_t'{4'd7, bits(src_bit[src], alu_bit[op])});
      exp_q.push_back(step_t'{4'd8, bits(25, 6, 26)});
    end else if (op == 6) begin
      exp_q.push_back(step_t'{4'd7, bits(src_bit[src], 1, 20, 26)});
    end else if (op == 7) begin
      exp_q.push_back(step_t'{4'd7, bits(7, instr[0] ? 18 : 16, 26)});
    end else if (op == 8) begin
      exp_q.push_back(step_t'{4'd7, bits(14, 6, 26)});
    end else begin
      exp_q.push_back(step_t'{4'd7, bits(14, 10, 26)});
    end
  endtask

  task automatic check_step(input string tag, input step_t e);
    check({tag, ".state"}, 32'(state), 32'(e.st));
    check({tag, ".cs"}, 32'(CS_bus), 32'(e.cw));
    check({tag, ".halted"}, 32'(halted), 32'(e.st == 4'd9));
    check({tag, ".alu1hot"}, 32'($countones(CS_bus[5:0]) <= 1), 32'd1);
    check({tag, ".rsvd"}, 32'(CS_bus[24:21]), 32'd0);
  endtask

  // Called at the falling edge of an F0 cycle; returns at the falling edge after the
  // last cycle of the instruction. Fetch-phase ir is garbage when scramble is set.
  task automatic run_instr(input logic [7:0] instr, input bit scramble, input string tag);
    build(instr);
    foreach (exp_q[i]) begin
      ir = (scramble && (exp_q[i].st == 4'd1 || exp_q[i].st == 4'd2)) ? 8'($urandom) : instr;
      #1;
      check_step(tag, exp_q[i]);
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [7:0] instr;
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.cs", 32'(CS_bus), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle.norun", 32'(state), 32'd0);
    run = 1'b1;
    @(negedge CLK);
    check("idle.to_f0", 32'(state), 32'd1);

    run_instr(8'h10, 1'b0, "add_b");
    run_instr(8'h42, 1'b0, "and_imm");
    run_instr(8'h61, 1'b0, "cmp_c");
    check("after_cmp", 32'(state), 32'd1);

    for (int n = 0; n < 60; n++) begin
      instr = 8'($urandom);
      if (instr[7:4] == 4'd10) instr[7:4] = 4'd0;
      run_instr(instr, 1'b1, "rand");
    end

    run_instr(8'hA0, 1'b1, "hlt");
    #1;
    check("halt.state", 32'(state), 32'd9);
    check("halt.flag", 32'(halted), 32'd1);
    check("halt.cs", 32'(CS_bus), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      check("halt.run_high", 32'(state), 32'd9);
    end
    run = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge CLK);
      check("halt.run_low", 32'(state), 32'd9);
    end
    run = 1'b1;
    @(negedge CLK);
    check("halt.resume", 32'(state), 32'd1);
    check("halt.cleared", 32'(halted), 32'd0);

    // Reset in the middle of a JMP execute cycle.
    build(8'h90);
    ir = 8'h90;
    foreach (exp_q[i]) begin
      #1;
      check_step("jmp", exp_q[i]);
      if (exp_q[i].st == 4'd7) break;
      @(negedge CLK);
    end
    RST_N = 1'b0;
    #1;
    check("jmp_rst.state", 32'(state), 32'd0);
    check("jmp_rst.cs", 32'(CS_bus), 32'd0);
    check("jmp_rst.pc_in", 32'(CS_bus[10]), 32'd0);
    @(negedge CLK);
    run = 1'b0;
    RST_N = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge CLK);
      check("post_rst.state", 32'(state), 32'd0);
      check("post_rst.cs", 32'(CS_bus), 32'd0);
    end
    run = 1'b1;
    @(negedge CLK);
    check("post_rst.go", 32'(state), 32'd1);
    run_instr(8'h21, 1'b1, "sub_c");
    run_instr(8'h73, 1'b1, "mov_c");
    run_instr(8'h33, 1'b1, "xor_acc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
